// File: rtl/mem_complete_arb_pkg.sv
// Shared constants and helper functions for the memory-to-complete arbiter.
package mem_cmp_pkg;

  // Default number of per-result flag bits.
  localparam int FLAG_W_DEF    = 3;

  // Flag bit positions within the flags field.
  localparam int FLG_FU_WR     = 0;
  localparam int FLG_FU_RD     = 1;
  localparam int FLG_FU_RD_MEM = 2;

  // Arbitration modes.
  localparam int PRIO_FIXED    = 0;
  localparam int PRIO_RR       = 1;

  // Width of a counter that must be able to hold the value 0..depth.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Width of an index selecting one of n items (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_complete_arb_if.sv
// Producer and completion-side bus of the memory-to-complete arbiter.
interface mem_cmp_if
  import mem_cmp_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int FLAG_W  = FLAG_W_DEF
) ();

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*PC_W-1:0]   src_pc;
  logic [NUM_SRC*FLAG_W-1:0] src_flags;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [PC_W-1:0]           out_pc;
  logic [FLAG_W-1:0]         out_flags;
  logic [NUM_SRC-1:0]        out_src;

  // Environment side: drives producer results and completion ready.
  modport master (
    output src_valid, src_data, src_pc, src_flags, out_ready,
    input  src_ready, out_valid, out_data, out_pc, out_flags, out_src
  );

  // Arbiter side.
  modport slave (
    input  src_valid, src_data, src_pc, src_flags, out_ready,
    output src_ready, out_valid, out_data, out_pc, out_flags, out_src
  );

endinterface

// File: rtl/mem_complete_arb_src_fifo.sv
// Small per-source circular FIFO with registered count and synchronous flush.
module cmp_src_fifo
  import mem_cmp_pkg::*;
#(
  parameter int WIDTH = 67,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  // Flush wins over both sides so nothing written in a flush cycle survives.
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers and occupancy, cleared by reset or flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_complete_arb.sv
// Memory-to-complete stage: per-source FIFOs, fixed or round-robin arbiter,
// and a registered completion port with valid/ready backpressure.
module mem_complete_arb
  import mem_cmp_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int FLAG_W     = FLAG_W_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int PRIO_MODE  = PRIO_FIXED
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     flush,
  mem_cmp_if.slave bus
);

  localparam int EW = FLAG_W + PC_W + DATA_W;
  localparam int RW = idx_width(NUM_SRC);
  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [EW-1:0]      w_head [NUM_SRC];
  logic [CW-1:0]      w_count [NUM_SRC];
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic               w_ld;
  logic               w_grant_vld;
  logic [RW-1:0]      w_grant_idx;
  logic [RW-1:0]      w_base;
  logic [RW:0]        w_sum;
  logic [RW-1:0]      w_rr_next;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [PC_W-1:0]    r_out_pc;
  logic [FLAG_W-1:0]  r_out_flags;
  logic [NUM_SRC-1:0] r_out_src;
  logic [RW-1:0]      r_rr_ptr;

  // Output register may load whenever it is empty or being consumed.
  assign w_ld = ~r_out_valid | bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      // Ready looks only at the registered count: no pass-through from a pop.
      assign bus.src_ready[gi] = (w_count[gi] < CW'(FIFO_DEPTH));
      assign w_push[gi] = bus.src_valid[gi] & ~w_full[gi];
      assign w_pop[gi]  = w_ld & w_grant_vld & ~flush & (w_grant_idx == RW'(gi));

      cmp_src_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .push  (w_push[gi]),
        .pop   (w_pop[gi]),
        .din   ({bus.src_flags[gi*FLAG_W +: FLAG_W],
                 bus.src_pc[gi*PC_W +: PC_W],
                 bus.src_data[gi*DATA_W +: DATA_W]}),
        .dout  (w_head[gi]),
        .count (w_count[gi]),
        .full  (w_full[gi]),
        .empty (w_empty[gi])
      );
    end
  endgenerate

  // Pick the first non-empty FIFO searching upward from the base with wrap.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    w_base      = (PRIO_MODE == PRIO_RR) ? r_rr_ptr : '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, w_base} + (RW+1)'(k);
      if (w_sum >= (RW+1)'(NUM_SRC)) w_sum = w_sum - (RW+1)'(NUM_SRC);
      if (!w_grant_vld && !w_empty[w_sum[RW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_sum[RW-1:0];
      end
    end
  end

  assign w_rr_next = (w_grant_idx == RW'(NUM_SRC - 1)) ? '0 : w_grant_idx + RW'(1);

  // Completion register: flush dominates, stall holds, load takes the winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_pc    <= '0;
      r_out_flags <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_ld) begin
      r_out_valid <= w_grant_vld;
      if (w_grant_vld) begin
        {r_out_flags, r_out_pc, r_out_data} <= w_head[w_grant_idx];
        r_out_src <= NUM_SRC'(1) << w_grant_idx;
        r_rr_ptr  <= w_rr_next;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_pc    = r_out_pc;
  assign bus.out_flags = r_out_flags;
  assign bus.out_src   = r_out_src;

endmodule

// File: doc/mem_complete_arb.md
Name: mem_complete_arb

Overview:
Parametrised memory-to-complete stage. Collects load results from NUM_SRC producers (src 0 = LSQ store-to-load forward, src 1 = data memory, further ports for extra memory channels), buffers each in a small per-source FIFO and arbitrates one result per cycle into a registered completion port with valid/ready backpressure. This replaces the fixed two-source MEM/complete pipeline register. It adds queuing, selectable priority, flush and stall handling.

Parameters:
NUM_SRC, 2, number of producer channels (>=1)
DATA_W, 32, load data width
PC_W, 32, instruction PC width
FLAG_W, 3, per-result flag bits: [0] FU write, [1] FU read, [2] FU read from MEM
FIFO_DEPTH, 2, entries per source FIFO (>=1; not required to be a power of 2)
PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
src_valid  in  NUM_SRC  per-source result valid
src_ready  out  NUM_SRC  per-source FIFO can accept
src_data  in  NUM_SRC*DATA_W  load data, source i at [i*DATA_W +: DATA_W]
src_pc  in  NUM_SRC*PC_W  PC, same packing
src_flags  in  NUM_SRC*FLAG_W  flags, same packing
out_valid  out  1  completion result valid
out_ready  in  1  completion stage accepts
out_data  out  DATA_W  selected load data
out_pc  out  PC_W  selected PC
out_flags  out  FLAG_W  selected flags
out_src  out  NUM_SRC  one-hot source of the current result

Behaviour:
- Reset: the asynchronous active-low rstn clears all FIFOs (count=0, pointers=0), out_valid=0, out_data=0, out_pc=0, out_flags=0, out_src=0, and sets the RR pointer to 0. src_ready goes high on the first cycle after reset release.
- Enqueue: source i writes when src_valid[i] && src_ready[i]. src_ready[i] = (count_i < FIFO_DEPTH) and is driven from registered count only. There is no same-cycle pass-through from dequeue, so a full FIFO still shows ready=0 in the cycle it is dequeued.
- Per-source FIFO: strict FIFO order within a source; circular pointers wrap at FIFO_DEPTH-1 -> 0. Simultaneous enqueue and dequeue leaves count unchanged.
- Load enable: ld = ~out_valid | out_ready. When ld is high and any FIFO is non-empty, the arbiter grants one source. The granted head is written to the output registers, that FIFO is popped, and out_valid=1 next cycle. When ld is high and all FIFOs are empty, out_valid=0 next cycle and the data registers hold their values.
- Stall: when out_valid && ~out_ready, all out_* registers hold and no FIFO is popped.
- Arbitration: with PRIO_MODE=0, the lowest-index non-empty FIFO wins. With PRIO_MODE=1, search starts at rr_ptr and proceeds upward with wrap. After each grant, rr_ptr = winner+1, wrapping to 0 past NUM_SRC-1. rr_ptr is unchanged when there is no grant.
- Latency: with empty FIFOs and out_ready=1, a result accepted at edge N appears with out_valid=1 after edge N+1 (2-cycle src->out). Sustained throughput is 1 result per cycle total.
- Flush: synchronous and dominant. In a flush cycle, all FIFO counts and pointers clear, out_valid=0, and rr_ptr=0. Enqueues in the same cycle are discarded and no grant occurs. Data registers need not clear. src_ready is 1 on the cycle after flush.
- Reset mid-operation: asynchronous clear regardless of in-flight data; outputs reach their reset values immediately.
- out_src is one-hot and equals the winner at load time. It clears to 0 only on reset or flush.

Decomposition:
- Package mem_cmp_pkg holds:
  - FLAG_W default;
  - flag bit indices FLG_FU_WR=0, FLG_FU_RD=1, FLG_FU_RD_MEM=2;
  - PRIO_FIXED=0, PRIO_RR=1;
  - a clog2-based count width function.
- Sub-module cmp_src_fifo, one instance per source. It has clk, rstn, flush, push, pop, din {flags,pc,data}, dout, count, full and empty. Parameters are WIDTH and DEPTH.
- Arbiter and output register live in the top module.

Test Plan:
- Reset/basic: release reset, set src_valid=01 with data=0xDEADBEEF, pc=0x100, flags=3'b001, out_ready=1 -> out_valid=1 after 2 edges with out_data=0xDEADBEEF, out_pc=0x100, out_src=01; src_ready=11 throughout.
- Fixed priority: PRIO_MODE=0, both sources push in the same cycle (src0 data=0xA, src1 data=0xB) -> outputs on consecutive cycles 0xA then 0xB; out_src 01 then 10.
- Round-robin: PRIO_MODE=1, NUM_SRC=3, all three FIFOs hold 2 entries -> out_src sequence 001,010,100,001,010,100.
- Backpressure/full: FIFO_DEPTH=2, out_ready=0, src1 pushes 4 results -> src_ready[1]=0 after 2 accepts plus one into the output register. Raise out_ready -> 3 results drain in push order; the 4th is never accepted while ready=0.
- Stall hold: out_valid=1 with out_data=0x55, out_ready=0 for 5 cycles while src0 pushes 0x66 -> out_data stays 0x55; 0x66 appears the cycle after out_ready=1.
- Flush: 2 entries queued per source and out_valid=1, pulse flush together with src_valid=11 -> next cycle out_valid=0, all counts 0, src_ready=11, and no flushed or same-cycle data ever appears on the output.
